// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, reads one instruction at a time over
// an AR/R read channel and hands {pc, inst, fault} to decode via valid/ready.
// Ports:
//   clock, reset                      - clock, synchronous active-high reset
//   arvalid_o/arready_i/araddr_o      - read-address channel to instruction memory
//   rvalid_i/rready_o/rdata_i/rresp_i - read-data channel from instruction memory
//   redirect_valid_i/redirect_pc_i    - PC change request from downstream
//   valid_o/ready_i/pc_o/inst_o/fault_o - instruction handoff to decode
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          INST_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [31:0]       araddr_o,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [INST_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              fault_o
);

    typedef enum logic [1:0] {
        S_AR   = 2'd0,
        S_R    = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic              squash_q, squash_d;
    logic [31:0]       pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              fault_q, fault_d;
    logic              arvalid_c, rready_c, valid_c;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        squash_d   = squash_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        fault_d    = fault_q;
        arvalid_c  = 1'b0;
        rready_c   = 1'b0;
        valid_c    = 1'b0;
        unique case (state_q)
            S_AR: begin
                arvalid_c = 1'b1;
                if (redirect_valid_i) begin
                    fetch_pc_d = redirect_pc_i;
                end
                if (arready_i) begin
                    state_d = S_R;
                    // Address already went out with the old PC: its data is wrong-path.
                    if (redirect_valid_i) begin
                        squash_d = 1'b1;
                    end
                end
            end
            S_R: begin
                rready_c = 1'b1;
                if (redirect_valid_i) begin
                    fetch_pc_d = redirect_pc_i;
                    if (rvalid_i) begin
                        squash_d = 1'b0;
                        state_d  = S_AR;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (rvalid_i) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = S_AR;
                    end else begin
                        pc_d    = fetch_pc_q;
                        fault_d = (rresp_i != 2'b00);
                        inst_d  = (rresp_i == 2'b00) ? rdata_i : INST_W'(32'h0000_0013);
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // A redirect kills the held instruction in the same cycle.
                valid_c = ~redirect_valid_i;
                if (redirect_valid_i) begin
                    fetch_pc_d = redirect_pc_i;
                    state_d    = S_AR;
                end else if (ready_i) begin
                    fetch_pc_d = pc_q + 32'd4;
                    state_d    = S_AR;
                end
            end
            default: begin
                state_d = S_AR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_AR;
            fetch_pc_q <= RESET_PC;
            squash_q   <= 1'b0;
            pc_q       <= 32'd0;
            inst_q     <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            squash_q   <= squash_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            fault_q    <= fault_d;
        end
    end

    // Outputs are forced idle while reset is held, even before the first edge.
    assign arvalid_o = arvalid_c & ~reset;
    assign rready_o  = rready_c & ~reset;
    assign valid_o   = valid_c & ~reset;
    assign araddr_o  = fetch_pc_q;
    assign pc_o      = reset ? 32'd0 : pc_q;
    assign inst_o    = reset ? '0 : inst_q;
    assign fault_o   = reset ? 1'b0 : fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a per-cycle vector table for the
// straight-line flow, then hand sequences for redirect, wrap and reset.
module tb_ifu_fetch;

    logic        clock;
    logic        reset;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] araddr_o;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        fault_o;

    int n_chk  = 0;
    int n_fail = 0;

    ifu_fetch dut (
        .clock           (clock),
        .reset           (reset),
        .arvalid_o       (arvalid_o),
        .arready_i       (arready_i),
        .araddr_o        (araddr_o),
        .rvalid_i        (rvalid_i),
        .rready_o        (rready_o),
        .rdata_i         (rdata_i),
        .rresp_i         (rresp_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .fault_o         (fault_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        arr;
        logic        rv;
        logic [31:0] rd;
        logic [1:0]  rr;
        logic        rdv;
        logic [31:0] rdpc;
        logic        rdy;
        logic        e_arv;
        logic [31:0] e_ara;
        logic        e_rrdy;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_f;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic rst, logic arr, logic rv, logic [31:0] rd, logic [1:0] rr,
        logic rdv, logic [31:0] rdpc, logic rdy,
        logic e_arv, logic [31:0] e_ara, logic e_rrdy, logic e_v,
        logic [31:0] e_pc, logic [31:0] e_inst, logic e_f);
        vec_t v;
        v.rst = rst; v.arr = arr; v.rv = rv; v.rd = rd; v.rr = rr;
        v.rdv = rdv; v.rdpc = rdpc; v.rdy = rdy;
        v.e_arv = e_arv; v.e_ara = e_ara; v.e_rrdy = e_rrdy; v.e_v = e_v;
        v.e_pc = e_pc; v.e_inst = e_inst; v.e_f = e_f;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    localparam logic [31:0] I0 = 32'h0000_0513;
    localparam logic [31:0] I1 = 32'h0010_0093;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Steps through AR -> R -> HOLD with zero-wait memory and ready_i=1.
    task automatic add_fetch(logic [31:0] a, logic [1:0] rr, logic [31:0] e_inst, logic e_f);
        vecs.push_back(mk(0,1,1,I0,2'b00,0,0,1, 1,a,0,0,0,0,0));
        vecs.push_back(mk(0,1,1,I0,rr,   0,0,1, 0,0,1,0,0,0,0));
        vecs.push_back(mk(0,1,1,I0,2'b00,0,0,1, 0,0,0,1,a,e_inst,e_f));
    endtask

    initial begin
        reset = 1'b1;
        arready_i = 1'b0;
        rvalid_i = 1'b0;
        rdata_i = '0;
        rresp_i = 2'b00;
        redirect_valid_i = 1'b0;
        redirect_pc_i = '0;
        ready_i = 1'b0;

        // Straight-line flow, backpressure and a faulting fetch.
        vecs.push_back(mk(1,1,1,I0,2'b00,0,0,1, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,I0,2'b00,0,0,1, 0,0,0,0,0,0,0));
        add_fetch(32'h8000_0000, 2'b00, I0, 0);
        vecs.push_back(mk(0,1,1,I0,2'b00,0,0,1, 1,32'h8000_0004,0,0,0,0,0));
        vecs.push_back(mk(0,1,1,I0,2'b00,0,0,1, 0,0,1,0,0,0,0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0,1,1,I0,2'b00,0,0,0, 0,0,0,1,32'h8000_0004,I0,0));
        vecs.push_back(mk(0,1,1,I0,2'b00,0,0,1, 0,0,0,1,32'h8000_0004,I0,0));
        add_fetch(32'h8000_0008, 2'b00, I0, 0);
        add_fetch(32'h8000_000C, 2'b00, I0, 0);
        add_fetch(32'h8000_0010, 2'b10, NOP, 1);
        vecs.push_back(mk(0,1,1,I0,2'b00,0,0,1, 1,32'h8000_0014,0,0,0,0,0));

        foreach (vecs[i]) begin
            tick();
            reset = vecs[i].rst;
            arready_i = vecs[i].arr;
            rvalid_i = vecs[i].rv;
            rdata_i = vecs[i].rd;
            rresp_i = vecs[i].rr;
            redirect_valid_i = vecs[i].rdv;
            redirect_pc_i = vecs[i].rdpc;
            ready_i = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d arvalid", i), 32'(arvalid_o), 32'(vecs[i].e_arv));
            chk($sformatf("v%0d rready", i), 32'(rready_o), 32'(vecs[i].e_rrdy));
            chk($sformatf("v%0d valid", i), 32'(valid_o), 32'(vecs[i].e_v));
            if (vecs[i].e_arv)
                chk($sformatf("v%0d araddr", i), araddr_o, vecs[i].e_ara);
            if (vecs[i].e_v || vecs[i].rst) begin
                chk($sformatf("v%0d pc", i), pc_o, vecs[i].e_pc);
                chk($sformatf("v%0d inst", i), inst_o, vecs[i].e_inst);
                chk($sformatf("v%0d fault", i), 32'(fault_o), 32'(vecs[i].e_f));
            end
        end

        // Redirect in S_R with a late response.
        tick(); reset = 1'b1; arready_i = 0; rvalid_i = 0; ready_i = 1;
        rresp_i = 2'b00; rdata_i = I1;
        tick(); reset = 1'b0; arready_i = 1;
        #1; chk("rs ar addr", araddr_o, 32'h8000_0000);
        tick(); arready_i = 0;
        #1; chk("rs rready", 32'(rready_o), 1);
        tick(); redirect_valid_i = 1; redirect_pc_i = 32'h8000_1000;
        #1; chk("rs v0", 32'(valid_o), 0);
        tick(); redirect_valid_i = 0;
        #1; chk("rs v1", 32'(valid_o), 0);
        tick(); rvalid_i = 1;
        #1; chk("rs v2", 32'(valid_o), 0);
        tick(); rvalid_i = 0;
        #1; chk("rs v3", 32'(valid_o), 0);
        chk("rs arvalid", 32'(arvalid_o), 1);
        chk("rs new addr", araddr_o, 32'h8000_1000);
        arready_i = 1;
        tick(); arready_i = 0; rvalid_i = 1;
        tick(); rvalid_i = 0; ready_i = 0;
        #1; chk("rs deliver v", 32'(valid_o), 1);
        chk("rs deliver pc", pc_o, 32'h8000_1000);
        chk("rs deliver inst", inst_o, I1);

        // Redirect in S_HOLD with ready_i=1 in the same cycle.
        tick(); ready_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h8000_2000;
        #1; chk("rh masked v", 32'(valid_o), 0);
        tick(); redirect_valid_i = 0;
        #1; chk("rh v", 32'(valid_o), 0);
        chk("rh addr", araddr_o, 32'h8000_2000);

        // Redirect in S_AR before acceptance, to the top of the address space.
        tick(); redirect_valid_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
        #1; chk("wr old addr", araddr_o, 32'h8000_2000);
        tick(); redirect_valid_i = 0; arready_i = 1;
        #1; chk("wr new addr", araddr_o, 32'hFFFF_FFFC);
        tick(); arready_i = 0; rvalid_i = 1;
        tick(); rvalid_i = 0;
        #1; chk("wr pc", pc_o, 32'hFFFF_FFFC);
        tick(); arready_i = 1;
        #1; chk("wr wrap addr", araddr_o, 32'h0000_0000);

        // Reset while in S_R, then a stale response.
        tick(); arready_i = 0; reset = 1;
        #1; chk("rst rready", 32'(rready_o), 0);
        chk("rst arvalid", 32'(arvalid_o), 0);
        tick(); reset = 0; rvalid_i = 1;
        #1; chk("rst addr", araddr_o, 32'h8000_0000);
        chk("rst stale rready", 32'(rready_o), 0);
        tick();
        #1; chk("rst stale v", 32'(valid_o), 0);
        chk("rst still ar", 32'(arvalid_o), 1);
        arready_i = 1; rvalid_i = 0;
        tick(); arready_i = 0; rvalid_i = 1; rdata_i = I0;
        tick(); rvalid_i = 0; ready_i = 1;
        #1; chk("rst deliver pc", pc_o, 32'h8000_0000);
        chk("rst deliver v", 32'(valid_o), 1);

        // Redirect in S_AR coinciding with arready: old address, then squash.
        tick(); arready_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h8000_3000;
        #1; chk("sq old addr", araddr_o, 32'h8000_0004);
        tick(); arready_i = 0; redirect_valid_i = 0; rvalid_i = 1;
        #1; chk("sq rready", 32'(rready_o), 1);
        tick(); rvalid_i = 0;
        #1; chk("sq v", 32'(valid_o), 0);
        chk("sq arvalid", 32'(arvalid_o), 1);
        chk("sq new addr", araddr_o, 32'h8000_3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
